conv_tile_scheduler: RTL and testbench

Sequences the parallel MAC array over an output feature map. It walks filter groups (POF wide) and spatial tiles (PIX x PIY), and issues one tile per handshake to the pixel/weight fetch logic. Each MAC result is realigned with its tile coordinates through a PE_LAT-deep tag pipeline, then buffered in an output FIFO toward writeback. Credit-based issue guarantees that no result is lost under downstream backpressure.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/conv_tile_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution tile scheduler.
// Tile tags are packed MSB first as {last, filt, y, x}.
package conv_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } sched_state_t;

  localparam int TAG_LAST_W = 1;

  function automatic int tag_width(input int filt_w, input int dim_w);
    return TAG_LAST_W + filt_w + 2 * dim_w;
  endfunction

  // Occupancy/credit counters must represent 0..depth inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; in FWFT mode the head is visible
// without a pop and reads as zero while the FIFO is empty.
module sync_fifo import conv_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit FWFT  = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  push_data,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  head,
  output logic                              valid,
  output logic [credit_width(DEPTH)-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = credit_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  if (FWFT) begin : g_fwft
    assign head = valid ? mem[rd_ptr] : '0;
  end else begin : g_reg
    logic [WIDTH-1:0] head_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         head_q <= '0;
      else if (do_pop) head_q <= mem[rd_ptr];
    end
    assign head = head_q;
  end

  // Upstream credit accounting should make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !do_pop));

endmodule

// File: rtl/conv_tile_scheduler.sv
// Walks filter groups and spatial tiles for the MAC array, carries each tile's
// coordinates alongside the MAC latency, and buffers tagged results for writeback.
module conv_tile_scheduler import conv_pkg::*; #(
  parameter int POF        = 4,
  parameter int PIX        = 1,
  parameter int PIY        = 1,
  parameter int ACC_WIDTH  = 33,
  parameter int PE_LAT     = 3,
  parameter int DIM_W      = 10,
  parameter int FILT_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DIM_W-1:0]                  cfg_out_w,
  input  logic [DIM_W-1:0]                  cfg_out_h,
  input  logic [FILT_W-1:0]                 cfg_num_filt,
  output logic                              busy,
  output logic                              done,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [FILT_W-1:0]                 issue_filt_base,
  output logic [DIM_W-1:0]                  issue_y,
  output logic [DIM_W-1:0]                  issue_x,
  input  logic [POF*PIX*PIY*ACC_WIDTH-1:0]  mac_results_flat,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [POF*PIX*PIY*ACC_WIDTH-1:0]  out_data,
  output logic [FILT_W-1:0]                 out_filt_base,
  output logic [DIM_W-1:0]                  out_y,
  output logic [DIM_W-1:0]                  out_x,
  output logic                              out_last
);

  // state | meaning
  // IDLE  | waiting for start; nothing issued
  // RUN   | issuing tiles whenever a result slot is guaranteed
  // DRAIN | every tile issued; waiting for the last result to be popped
  // FIN   | layer complete; done pulses on the following cycle

  localparam int DATA_W = POF * PIX * PIY * ACC_WIDTH;
  localparam int TAG_W  = tag_width(FILT_W, DIM_W);
  localparam int CW     = credit_width(FIFO_DEPTH);

  localparam logic [DIM_W:0]  X_STEP  = (DIM_W + 1)'(PIX);
  localparam logic [DIM_W:0]  Y_STEP  = (DIM_W + 1)'(PIY);
  localparam logic [FILT_W:0] F_STEP  = (FILT_W + 1)'(POF);
  localparam logic [CW:0]     CREDITS = (CW + 1)'(FIFO_DEPTH);

  sched_state_t        state;
  logic [DIM_W-1:0]    cfg_w;
  logic [DIM_W-1:0]    cfg_h;
  logic [FILT_W-1:0]   cfg_nf;
  logic [DIM_W-1:0]    x;
  logic [DIM_W-1:0]    y;
  logic [FILT_W-1:0]   f;
  logic [DIM_W:0]      x_sum;
  logic [DIM_W:0]      y_sum;
  logic [FILT_W:0]     f_sum;
  logic                x_wrap;
  logic                y_wrap;
  logic                f_wrap;
  logic                last_tile;
  logic                cfg_zero;
  logic                hs;
  logic                pop;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       fifo_count;
  logic [CW:0]         used;
  logic [PE_LAT-1:0]   pipe_v;
  logic [PE_LAT:0]     pipe_v_in;
  logic [TAG_W-1:0]    pipe_tag [PE_LAT];
  logic [TAG_W-1:0]    issue_tag;
  logic [TAG_W+DATA_W-1:0] head;

  // One extra bit on the sums keeps the wrap compare exact at the maximum dimension.
  assign x_sum     = {1'b0, x} + X_STEP;
  assign y_sum     = {1'b0, y} + Y_STEP;
  assign f_sum     = {1'b0, f} + F_STEP;
  assign x_wrap    = (x_sum >= {1'b0, cfg_w});
  assign y_wrap    = (y_sum >= {1'b0, cfg_h});
  assign f_wrap    = (f_sum >= {1'b0, cfg_nf});
  assign last_tile = x_wrap && y_wrap && f_wrap;
  assign cfg_zero  = (cfg_out_w == '0) || (cfg_out_h == '0) || (cfg_num_filt == '0);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PE_LAT; i++) inflight = inflight + CW'(pipe_v[i]);
  end

  // Only issue when a FIFO slot is reserved for every result still in the MAC pipe.
  assign used        = {1'b0, inflight} + {1'b0, fifo_count};
  assign issue_valid = (state == S_RUN) && (used < CREDITS);
  assign hs          = issue_valid && issue_ready;
  assign pop         = out_valid && out_ready;

  assign issue_filt_base = f;
  assign issue_y         = y;
  assign issue_x         = x;
  assign issue_tag       = {last_tile, f, y, x};
  assign pipe_v_in       = {pipe_v, hs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cfg_w  <= '0;
      cfg_h  <= '0;
      cfg_nf <= '0;
      x      <= '0;
      y      <= '0;
      f      <= '0;
      pipe_v <= '0;
    end else begin
      done   <= 1'b0;
      pipe_v <= pipe_v_in[PE_LAT-1:0];
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_w  <= cfg_out_w;
            cfg_h  <= cfg_out_h;
            cfg_nf <= cfg_num_filt;
            x      <= '0;
            y      <= '0;
            f      <= '0;
            busy   <= 1'b1;
            state  <= cfg_zero ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          if (hs) begin
            if (!x_wrap) begin
              x <= x_sum[DIM_W-1:0];
            end else begin
              x <= '0;
              if (!y_wrap) begin
                y <= y_sum[DIM_W-1:0];
              end else begin
                y <= '0;
                f <= f_wrap ? '0 : f_sum[FILT_W-1:0];
              end
            end
            if (last_tile) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && out_last) state <= S_FIN;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    pipe_tag[0] <= issue_tag;
    for (int i = 1; i < PE_LAT; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  sync_fifo #(
    .WIDTH (TAG_W + DATA_W),
    .DEPTH (FIFO_DEPTH),
    .FWFT  (1'b1)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_v[PE_LAT-1]),
    .push_data ({pipe_tag[PE_LAT-1], mac_results_flat}),
    .pop       (pop),
    .head      (head),
    .valid     (out_valid),
    .count     (fifo_count)
  );

  assign {out_last, out_filt_base, out_y, out_x, out_data} = head;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Randomized bench for conv_tile_scheduler against a tile-list / latency reference model.
module tb_conv_tile_scheduler;

  localparam int POF    = 4;
  localparam int PIX    = 1;
  localparam int PIY    = 1;
  localparam int ACC    = 33;
  localparam int PE_LAT = 3;
  localparam int DW     = 10;
  localparam int FW     = 10;
  localparam int DEPTH  = 4;
  localparam int DATA_W = POF * PIX * PIY * ACC;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [DW-1:0]     cfg_out_w = '0;
  logic [DW-1:0]     cfg_out_h = '0;
  logic [FW-1:0]     cfg_num_filt = '0;
  logic              busy, done, issue_valid, out_valid, out_last;
  logic              issue_ready = 1'b0;
  logic              out_ready = 1'b0;
  logic [FW-1:0]     issue_filt_base, out_filt_base;
  logic [DW-1:0]     issue_y, issue_x, out_y, out_x;
  logic [DATA_W-1:0] mac = '0;
  logic [DATA_W-1:0] out_data;

  conv_tile_scheduler #(
    .POF(POF), .PIX(PIX), .PIY(PIY), .ACC_WIDTH(ACC), .PE_LAT(PE_LAT),
    .DIM_W(DW), .FILT_W(FW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h), .cfg_num_filt(cfg_num_filt),
    .busy(busy), .done(done),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_filt_base(issue_filt_base), .issue_y(issue_y), .issue_x(issue_x),
    .mac_results_flat(mac),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_filt_base(out_filt_base), .out_y(out_y), .out_x(out_x), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {int f; int y; int x; bit last;} tile_t;
  typedef struct {int t; tile_t tl;} hs_t;
  typedef struct {tile_t tl; logic [DATA_W-1:0] d;} res_t;

  tile_t tiles_q[$];
  hs_t   hs_q[$];
  res_t  exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_at = -1;
  int n_hs = 0;
  int hs_cyc = -1;
  int ov_cyc = -1;
  bit exp_busy = 0;
  bit exp_run = 0;
  bit exp_done = 0;

  task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [FW+2*DW-1:0] tagv(input tile_t t);
    return {FW'(t.f), DW'(t.y), DW'(t.x)};
  endfunction

  function automatic logic pick(input int m);
    if (m == 0) return 1'b0;
    if (m == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic build_tiles(input int w, input int h, input int nf);
    tile_t t;
    tiles_q.delete();
    for (int fi = 0; fi < nf; fi += POF)
      for (int yi = 0; yi < h; yi += PIY)
        for (int xi = 0; xi < w; xi += PIX) begin
          t = '{fi, yi, xi, 1'b0};
          tiles_q.push_back(t);
        end
    tiles_q[tiles_q.size()-1].last = 1'b1;
  endtask

  task automatic reset_model();
    tiles_q.delete();
    hs_q.delete();
    exp_q.delete();
    exp_busy = 0;
    exp_run  = 0;
    exp_done = 0;
    done_at  = -1;
  endtask

  // One clock cycle: compare outputs, drive inputs, advance the reference model.
  task automatic step(input bit st, input int irm, input int orm);
    logic [159:0] rnd;
    bit hs, pop;
    int used;
    tile_t tl;
    hs_t h;
    res_t r;
    @(negedge clk);
    used = hs_q.size() + exp_q.size();
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("issue_valid", issue_valid, exp_run && (used < DEPTH));
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (out_valid && ov_cyc < 0) ov_cyc = cyc;
    start       = st;
    issue_ready = pick(irm);
    out_ready   = pick(orm);
    rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
    mac = rnd[DATA_W-1:0];
    hs  = issue_valid && issue_ready;
    pop = out_valid && out_ready;
    if (hs) begin
      n_hs++;
      if (hs_cyc < 0) hs_cyc = cyc;
      if (tiles_q.size() == 0) chk("extra_issue", 1, 0);
      else begin
        tl = tiles_q.pop_front();
        chk("issue_tag", {issue_filt_base, issue_y, issue_x}, tagv(tl));
        h = '{cyc, tl};
        hs_q.push_back(h);
        if (tl.last) exp_run = 0;
      end
    end
    if (pop) begin
      if (exp_q.size() == 0) chk("extra_result", 1, 0);
      else begin
        r = exp_q.pop_front();
        chk("out_tag", {out_filt_base, out_y, out_x}, tagv(r.tl));
        chk("out_last", out_last, r.tl.last);
        chk("out_data", out_data, r.d);
        if (r.tl.last) done_at = cyc + 2;
      end
    end
    if (hs_q.size() != 0 && hs_q[0].t + PE_LAT == cyc) begin
      h = hs_q.pop_front();
      r = '{h.tl, mac};
      exp_q.push_back(r);
    end
    if (st && !exp_busy) begin
      exp_busy = 1;
      if (cfg_out_w == 0 || cfg_out_h == 0 || cfg_num_filt == 0) done_at = cyc + 2;
      else begin
        build_tiles(int'(cfg_out_w), int'(cfg_out_h), int'(cfg_num_filt));
        exp_run = 1;
      end
    end
    cyc++;
    exp_done = (cyc == done_at);
    if (exp_done) exp_busy = 0;
  endtask

  task automatic set_cfg(input int w, input int h, input int nf);
    cfg_out_w    = DW'(w);
    cfg_out_h    = DW'(h);
    cfg_num_filt = FW'(nf);
  endtask

  task automatic wait_idle(input int irm, input int orm, input int budget);
    int n = 0;
    while (exp_busy || exp_q.size() != 0 || hs_q.size() != 0) begin
      step(0, irm, orm);
      n++;
      if (n > budget) begin
        chk("timeout", 1, 0);
        break;
      end
    end
    step(0, irm, orm);
  endtask

  task automatic run_layer(input int w, input int h, input int nf, input int irm, input int orm);
    set_cfg(w, h, nf);
    step(1, irm, orm);
    wait_idle(irm, orm, 3000);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    run_layer(2, 2, 4, 1, 1);

    hs_cyc = -1;
    ov_cyc = -1;
    run_layer(1, 1, 1, 1, 1);
    chk("latency", ov_cyc - hs_cyc, PE_LAT + 1);

    set_cfg(4, 4, 4);
    n_hs = 0;
    step(1, 1, 0);
    repeat (5) step(0, 1, 0);
    step(1, 1, 0);
    repeat (24) step(0, 1, 0);
    chk("bp_issues", n_hs, 4);
    chk("bp_issue_valid", issue_valid, 0);
    wait_idle(1, 1, 3000);
    chk("bp_total_issues", n_hs, 16);

    n_hs = 0;
    run_layer(3, 2, 6, 2, 2);
    chk("f6_total_issues", n_hs, 12);

    n_hs = 0;
    set_cfg(0, 3, 4);
    step(1, 1, 1);
    step(1, 1, 1);
    wait_idle(1, 1, 20);
    chk("zero_cfg_issues", n_hs, 0);

    set_cfg(4, 4, 4);
    n_hs = 0;
    k = 0;
    step(1, 1, 0);
    while (n_hs < 2 && k < 20) begin
      step(0, 1, 0);
      k++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_issue_valid", issue_valid, 0);
    chk("mid_rst_issue_x", issue_x, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    start = 1'b0;
    issue_ready = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    run_layer(2, 2, 4, 1, 1);

    repeat (6) begin
      run_layer($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 9), 2, 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
